// File: rtl/rob_port_arbiter.sv
// rob_port_arbiter: shares the two ROB write ports among three writeback
// requesters (r0 = ALU, r1 = MEM, r2 = MUL). Up to two requests are granted per
// cycle in round-robin order. Each grant is registered into a per-port output
// stage that holds its request until the ROB accepts it.
module rob_port_arbiter #(
    parameter int REGISTER_SIZE    = 32,
    parameter int REG_ADDRESS_SIZE = 5,
    parameter int ID_SIZE          = 1
) (
    input  logic                        clk,
    input  logic                        reset,

    input  logic [ID_SIZE-1:0]          r0_id,
    input  logic [REG_ADDRESS_SIZE-1:0] r0_address,
    input  logic [REGISTER_SIZE-1:0]    r0_data,
    input  logic                        r0_w,
    input  logic                        r0_req,
    output logic                        r0_stall,

    input  logic [ID_SIZE-1:0]          r1_id,
    input  logic [REG_ADDRESS_SIZE-1:0] r1_address,
    input  logic [REGISTER_SIZE-1:0]    r1_data,
    input  logic                        r1_w,
    input  logic                        r1_req,
    output logic                        r1_stall,

    input  logic [ID_SIZE-1:0]          r2_id,
    input  logic [REG_ADDRESS_SIZE-1:0] r2_address,
    input  logic [REGISTER_SIZE-1:0]    r2_data,
    input  logic                        r2_w,
    input  logic                        r2_req,
    output logic                        r2_stall,

    output logic [ID_SIZE-1:0]          rob1_id,
    output logic [REG_ADDRESS_SIZE-1:0] rob1_address,
    output logic [REGISTER_SIZE-1:0]    rob1_data,
    output logic                        rob1_w,
    output logic                        rob1_req,
    input  logic                        rob1_stall,

    output logic [ID_SIZE-1:0]          rob2_id,
    output logic [REG_ADDRESS_SIZE-1:0] rob2_address,
    output logic [REGISTER_SIZE-1:0]    rob2_data,
    output logic                        rob2_w,
    output logic                        rob2_req,
    input  logic                        rob2_stall
);

    localparam int PW = ID_SIZE + REG_ADDRESS_SIZE + REGISTER_SIZE + 1;

    // Requester payloads packed as {id, address, data, w}
    logic [PW-1:0] pay [3];
    logic [2:0]    req_vec;
    logic [2:0]    win;
    logic [2:0]    stall_vec;

    assign pay[0]  = {r0_id, r0_address, r0_data, r0_w};
    assign pay[1]  = {r1_id, r1_address, r1_data, r1_w};
    assign pay[2]  = {r2_id, r2_address, r2_data, r2_w};
    assign req_vec = {r2_req, r1_req, r0_req};

    // Output stages and round-robin pointer
    logic [PW-1:0] stage1_reg, stage2_reg;
    logic          valid1_reg, valid2_reg;
    logic [1:0]    rr_ptr_reg, rr_ptr_next;

    assign {rob1_id, rob1_address, rob1_data, rob1_w} = stage1_reg;
    assign {rob2_id, rob2_address, rob2_data, rob2_w} = stage2_reg;
    assign rob1_req = valid1_reg;
    assign rob2_req = valid2_reg;

    // A stage is free when empty or when it drains at this edge
    logic       free1, free2;
    logic [1:0] free_cnt;
    assign free1    = !valid1_reg || !rob1_stall;
    assign free2    = !valid2_reg || !rob2_stall;
    assign free_cnt = {1'b0, free1} + {1'b0, free2};

    // Requesters are held off while in reset and whenever they did not win
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_stall
            assign stall_vec[gi] = !reset || (req_vec[gi] && !win[gi]);
        end
    endgenerate
    assign r0_stall = stall_vec[0];
    assign r1_stall = stall_vec[1];
    assign r2_stall = stall_vec[2];

    logic [1:0] nwin, first_idx, second_idx, last_idx;
    logic [2:0] scan;

    // Round-robin scan from rr_ptr: the first min(free slots, candidates) win
    always_comb begin
        win        = '0;
        nwin       = 2'd0;
        first_idx  = 2'd0;
        second_idx = 2'd0;
        last_idx   = rr_ptr_reg;
        scan       = 3'd0;
        for (int i = 0; i < 3; i++) begin
            scan = {1'b0, rr_ptr_reg} + 3'(i);
            if (scan >= 3'd3) scan = scan - 3'd3;
            if (req_vec[scan[1:0]] && (nwin < free_cnt)) begin
                win[scan[1:0]] = 1'b1;
                if (nwin == 2'd0) first_idx = scan[1:0];
                else              second_idx = scan[1:0];
                last_idx = scan[1:0];
                nwin     = nwin + 2'd1;
            end
        end
        rr_ptr_next = rr_ptr_reg;
        if (nwin != 2'd0) rr_ptr_next = (last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1;
    end

    // First winner goes to port 1 when free, otherwise port 2; a second winner
    // only exists when both ports are free and always lands on port 2.
    logic          load1, load2;
    logic [PW-1:0] load2_pay;
    assign load1     = free1 && (nwin != 2'd0);
    assign load2     = free1 ? (nwin == 2'd2) : (free2 && (nwin != 2'd0));
    assign load2_pay = free1 ? pay[second_idx] : pay[first_idx];

    // Stage registers: load a winner, clear on drain, otherwise hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage1_reg <= '0;
            stage2_reg <= '0;
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
            rr_ptr_reg <= 2'd0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            if (load1) begin
                stage1_reg <= pay[first_idx];
                valid1_reg <= 1'b1;
            end else if (free1) begin
                valid1_reg <= 1'b0;
            end
            if (load2) begin
                stage2_reg <= load2_pay;
                valid2_reg <= 1'b1;
            end else if (free2) begin
                valid2_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rob_port_arbiter.sv
// Randomized scoreboard bench for rob_port_arbiter. A reference model decides
// grants each cycle and queues the expected payload per ROB port; a monitor
// pops and compares whenever a ROB port transfers.
module tb_rob_port_arbiter;

    localparam int PW = 1 + 5 + 32 + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:0]  r_id   [3];
    logic [4:0]  r_addr [3];
    logic [31:0] r_data [3];
    logic        r_w    [3];
    logic        rq     [3];
    logic [2:0]  stall_o;
    logic [0:0]  rob1_id, rob2_id;
    logic [4:0]  rob1_address, rob2_address;
    logic [31:0] rob1_data, rob2_data;
    logic        rob1_w, rob2_w, rob1_req, rob2_req;
    logic        rob1_stall, rob2_stall;

    always #5 clk = ~clk;

    rob_port_arbiter dut (
        .clk(clk), .reset(reset),
        .r0_id(r_id[0]), .r0_address(r_addr[0]), .r0_data(r_data[0]), .r0_w(r_w[0]),
        .r0_req(rq[0]), .r0_stall(stall_o[0]),
        .r1_id(r_id[1]), .r1_address(r_addr[1]), .r1_data(r_data[1]), .r1_w(r_w[1]),
        .r1_req(rq[1]), .r1_stall(stall_o[1]),
        .r2_id(r_id[2]), .r2_address(r_addr[2]), .r2_data(r_data[2]), .r2_w(r_w[2]),
        .r2_req(rq[2]), .r2_stall(stall_o[2]),
        .rob1_id(rob1_id), .rob1_address(rob1_address), .rob1_data(rob1_data),
        .rob1_w(rob1_w), .rob1_req(rob1_req), .rob1_stall(rob1_stall),
        .rob2_id(rob2_id), .rob2_address(rob2_address), .rob2_data(rob2_data),
        .rob2_w(rob2_w), .rob2_req(rob2_req), .rob2_stall(rob2_stall)
    );

    int total = 0;
    int bad   = 0;
    bit done  = 0;

    logic [PW-1:0] q1[$], q2[$];

    // Reference model state: which stages hold an item, scan start, and
    // which requesters are waiting with a held payload
    bit m_valid1, m_valid2;
    int m_rr;
    bit pending [3];
    bit force_all;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] pack(int k);
        return {r_id[k], r_addr[k], r_data[k], r_w[k]};
    endfunction

    // Apply the arbitration rules to the current inputs and model state
    task automatic model_step();
        bit f1, f2;
        int nfree, nw;
        int cand[$];
        int slots[$];
        bit win [3];
        bit load1, load2;
        f1 = !m_valid1 || !rob1_stall;
        f2 = !m_valid2 || !rob2_stall;
        nfree = int'(f1) + int'(f2);
        for (int i = 0; i < 3; i++) begin
            int k;
            k = (m_rr + i) % 3;
            if (rq[k]) cand.push_back(k);
        end
        nw = (nfree < cand.size()) ? nfree : cand.size();
        if (f1) slots.push_back(1);
        if (f2) slots.push_back(2);
        for (int k = 0; k < 3; k++) win[k] = 0;
        load1 = 0;
        load2 = 0;
        for (int j = 0; j < nw; j++) begin
            win[cand[j]] = 1;
            if (slots[j] == 1) begin q1.push_back(pack(cand[j])); load1 = 1; end
            else               begin q2.push_back(pack(cand[j])); load2 = 1; end
        end
        check("rob1_req", 64'(rob1_req), 64'(m_valid1));
        check("rob2_req", 64'(rob2_req), 64'(m_valid2));
        for (int k = 0; k < 3; k++)
            check($sformatf("r%0d_stall", k), 64'(stall_o[k]), 64'(rq[k] && !win[k]));
        if (load1) m_valid1 = 1; else if (f1) m_valid1 = 0;
        if (load2) m_valid2 = 1; else if (f2) m_valid2 = 0;
        if (nw > 0) m_rr = (cand[nw-1] + 1) % 3;
        for (int k = 0; k < 3; k++) pending[k] = rq[k] && !win[k];
    endtask

    // Monitor: every ROB-side transfer must match the oldest expected item
    initial begin
        logic [PW-1:0] e;
        forever begin
            @(negedge clk);
            if (reset && !done) begin
                if (rob1_req && !rob1_stall) begin
                    if (q1.size() == 0) check("port1_unexpected", 64'(rob1_req), 64'(0));
                    else begin
                        e = q1.pop_front();
                        check("port1_payload", 64'({rob1_id, rob1_address, rob1_data, rob1_w}), 64'(e));
                        $display("xfer port1 id=%0d addr=%0d data=%08h w=%0b",
                                 rob1_id, rob1_address, rob1_data, rob1_w);
                    end
                end
                if (rob2_req && !rob2_stall) begin
                    if (q2.size() == 0) check("port2_unexpected", 64'(rob2_req), 64'(0));
                    else begin
                        e = q2.pop_front();
                        check("port2_payload", 64'({rob2_id, rob2_address, rob2_data, rob2_w}), 64'(e));
                        $display("xfer port2 id=%0d addr=%0d data=%08h w=%0b",
                                 rob2_id, rob2_address, rob2_data, rob2_w);
                    end
                end
            end
        end
    end

    // Stimulus: random requesters that hold while stalled, random ROB stalls
    initial begin
        int req_pct, st_pct;
        reset = 1'b1;
        rob1_stall = 1'b0;
        rob2_stall = 1'b0;
        for (int k = 0; k < 3; k++) begin
            r_id[k] = '0; r_addr[k] = '0; r_data[k] = '0; r_w[k] = 1'b0;
            rq[k] = 1'b0; pending[k] = 0;
        end
        m_valid1 = 0; m_valid2 = 0; m_rr = 0; force_all = 0;
        #1 reset = 1'b0;
        rq[1] = 1'b1;
        #2;
        check("reset_rob1_req", 64'(rob1_req), 64'(0));
        check("reset_rob2_req", 64'(rob2_req), 64'(0));
        check("reset_rob1_data", 64'(rob1_data), 64'(0));
        check("reset_stalls", 64'(stall_o), 64'(3'b111));
        rq[1] = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        for (int c = 0; c < 1200; c++) begin
            @(posedge clk); #1;
            if (c == 500) begin
                reset = 1'b0;
                #1;
                check("midrst_rob1_req", 64'(rob1_req), 64'(0));
                check("midrst_rob2_req", 64'(rob2_req), 64'(0));
                check("midrst_stalls", 64'(stall_o), 64'(3'b111));
                q1.delete(); q2.delete();
                m_valid1 = 0; m_valid2 = 0; m_rr = 0;
                for (int k = 0; k < 3; k++) pending[k] = 0;
                repeat (2) @(posedge clk);
                #1 reset = 1'b1;
                force_all = 1;
            end
            req_pct = (c == 0) ? 0 : 70;
            st_pct  = (c < 300) ? 0 : ((c < 800) ? 40 : 85);
            for (int k = 0; k < 3; k++) begin
                if (!pending[k]) begin
                    rq[k]     = force_all || ($urandom_range(99) < req_pct);
                    r_id[k]   = 1'($urandom);
                    r_addr[k] = 5'($urandom);
                    r_data[k] = $urandom;
                    r_w[k]    = 1'($urandom);
                end
            end
            rob1_stall = force_all ? 1'b0 : ($urandom_range(99) < st_pct);
            rob2_stall = force_all ? 1'b0 : ($urandom_range(99) < st_pct);
            @(negedge clk);
            if (force_all) check("post_reset_r0_first", 64'(stall_o[0]), 64'(0));
            force_all = 0;
            model_step();
        end

        @(posedge clk); #1;
        done = 1;
        check("port1_left", 64'(q1.size()), 64'(m_valid1));
        check("port2_left", 64'(q2.size()), 64'(m_valid2));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
